// File: rtl/rat_seq_pkg.sv
// Shared types for the instruction sequencer: state encodings,
// default interrupt vector base and the vector address helper.
package rat_seq_pkg;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_INT   = 3'd4
    } state_e;

    localparam int          IDX_W        = 3;
    localparam int          VEC_W        = 10;
    localparam int          CNT_W        = 2;
    localparam logic [9:0]  VEC_BASE_DEF = 10'h3F8;

    // Vector addresses wrap inside the 10-bit program space.
    function automatic logic [VEC_W-1:0] vec_addr(
        input logic [VEC_W-1:0] base,
        input logic [IDX_W-1:0] idx
    );
        return base + {{(VEC_W-IDX_W){1'b0}}, idx};
    endfunction

endpackage

// File: rtl/rat_irq_pend.sv
// Interrupt front end: rising-edge detect, pending latch and a
// lowest-index-first priority encoder over the unmasked pending set.
module rat_irq_pend
    import rat_seq_pkg::*;
#(
    parameter int N_IRQ = 4
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic [N_IRQ-1:0] irq_i,
    input  logic [N_IRQ-1:0] mask_i,
    input  logic [N_IRQ-1:0] ack_i,
    output logic             req_o,
    output logic [IDX_W-1:0] win_o
);

    logic [N_IRQ-1:0] irq_prev_q;
    logic [N_IRQ-1:0] pend_q;
    logic [N_IRQ-1:0] pend_d;
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] elig;
    logic             found;

    assign rise = irq_i & ~irq_prev_q;

    // A new edge outranks the acknowledge of the same source.
    assign pend_d = (pend_q & ~ack_i) | rise;

    // History resets high so a line held across reset is not an edge.
    always_ff @(posedge clk) begin
        if (RESET) begin
            irq_prev_q <= '1;
            pend_q     <= '0;
        end else begin
            irq_prev_q <= irq_i;
            pend_q     <= pend_d;
        end
    end

    assign elig  = pend_q & mask_i;
    assign req_o = |elig;

    always_comb begin
        win_o = '0;
        found = 1'b0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (!found && elig[i]) begin
                win_o = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rat_seq_ctrl.sv
// Instruction sequencer: INIT/FETCH/WAIT/EXEC/INT control with
// optional fetch wait states and vectored interrupt entry.
module rat_seq_ctrl
    import rat_seq_pkg::*;
#(
    parameter int         N_IRQ      = 4,
    parameter int         FETCH_WAIT = 0,
    parameter logic [9:0] VEC_BASE   = VEC_BASE_DEF
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic [N_IRQ-1:0] IRQ,
    input  logic [N_IRQ-1:0] IRQ_MASK,
    input  logic             I_FLAG,
    output logic             RST,
    output logic             PC_INC,
    output logic             EXEC_EN,
    output logic             INT_EN,
    output logic [9:0]       INT_VEC,
    output logic [N_IRQ-1:0] INT_ACK,
    output logic [2:0]       STATE
);

    localparam logic [CNT_W-1:0] WAIT_LD =
        (FETCH_WAIT > 0) ? CNT_W'(FETCH_WAIT - 1) : '0;

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [IDX_W-1:0] win_q;
    logic [IDX_W-1:0] win_d;
    logic             irq_req;
    logic [IDX_W-1:0] irq_win;

    rat_irq_pend #(
        .N_IRQ (N_IRQ)
    ) u_pend (
        .clk    (clk),
        .RESET  (RESET),
        .irq_i  (IRQ),
        .mask_i (IRQ_MASK),
        .ack_i  (INT_ACK),
        .req_o  (irq_req),
        .win_o  (irq_win)
    );

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        unique case (state_q)
            ST_INIT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (FETCH_WAIT == 0) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = WAIT_LD;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_EXEC;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            // Interrupt decision and winner capture happen only here.
            ST_EXEC: begin
                if (I_FLAG && irq_req) begin
                    state_d = ST_INT;
                    win_d   = irq_win;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_INT: begin
                state_d = ST_FETCH;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_comb begin
        RST     = 1'b0;
        PC_INC  = 1'b0;
        EXEC_EN = 1'b0;
        INT_EN  = 1'b0;
        INT_VEC = '0;
        INT_ACK = '0;
        unique case (state_q)
            ST_INIT:  RST     = 1'b1;
            ST_FETCH: PC_INC  = 1'b1;
            ST_WAIT:  ;
            ST_EXEC:  EXEC_EN = 1'b1;
            ST_INT: begin
                INT_EN  = 1'b1;
                INT_VEC = vec_addr(VEC_BASE, win_q);
                for (int i = 0; i < N_IRQ; i++) begin
                    INT_ACK[i] = (win_q == IDX_W'(i));
                end
            end
            default: ;
        endcase
    end

    assign STATE = state_q;

endmodule

// File: tb/tb_rat_seq_ctrl.sv
// Directed bench: two sequencer instances (no wait states and two
// wait states) driven through reset, sequencing and interrupt cases.
module tb_rat_seq_ctrl;

    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_INT   = 3'd4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq;
    logic [3:0] mask;
    logic       iflag;
    logic       a_rst, a_pc, a_ex, a_int;
    logic [9:0] a_vec;
    logic [3:0] a_ack;
    logic [2:0] a_st;

    logic       b_reset;
    logic [3:0] b_irq;
    logic [3:0] b_mask;
    logic       b_iflag;
    logic       b_rst, b_pc, b_ex, b_int;
    logic [9:0] b_vec;
    logic [3:0] b_ack;
    logic [2:0] b_st;

    int checks = 0;
    int errors = 0;
    int t = 0;

    always #5 clk = ~clk;

    rat_seq_ctrl #(.N_IRQ(4), .FETCH_WAIT(0), .VEC_BASE(10'h3F8)) dut_a (
        .clk(clk), .RESET(reset), .IRQ(irq), .IRQ_MASK(mask),
        .I_FLAG(iflag), .RST(a_rst), .PC_INC(a_pc), .EXEC_EN(a_ex),
        .INT_EN(a_int), .INT_VEC(a_vec), .INT_ACK(a_ack), .STATE(a_st)
    );

    rat_seq_ctrl #(.N_IRQ(4), .FETCH_WAIT(2), .VEC_BASE(10'h3F8)) dut_b (
        .clk(clk), .RESET(b_reset), .IRQ(b_irq), .IRQ_MASK(b_mask),
        .I_FLAG(b_iflag), .RST(b_rst), .PC_INC(b_pc), .EXEC_EN(b_ex),
        .INT_EN(b_int), .INT_VEC(b_vec), .INT_ACK(b_ack), .STATE(b_st)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0d: observed %0h expected %0h",
                   tag, t, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [2:0] st,
                         input logic [9:0] vec, input logic [3:0] ack);
        chk({tag, ".STATE"},   32'(a_st),  32'(st));
        chk({tag, ".RST"},     32'(a_rst), 32'(st == S_INIT));
        chk({tag, ".PC_INC"},  32'(a_pc),  32'(st == S_FETCH));
        chk({tag, ".EXEC_EN"}, 32'(a_ex),  32'(st == S_EXEC));
        chk({tag, ".INT_EN"},  32'(a_int), 32'(st == S_INT));
        chk({tag, ".INT_VEC"}, 32'(a_vec), 32'(vec));
        chk({tag, ".INT_ACK"}, 32'(a_ack), 32'(ack));
    endtask

    task automatic chk_b(input string tag, input logic [2:0] st);
        chk({tag, ".STATE"},   32'(b_st),  32'(st));
        chk({tag, ".RST"},     32'(b_rst), 32'(st == S_INIT));
        chk({tag, ".PC_INC"},  32'(b_pc),  32'(st == S_FETCH));
        chk({tag, ".EXEC_EN"}, 32'(b_ex),  32'(st == S_EXEC));
        chk({tag, ".INT_EN"},  32'(b_int), 32'(1'b0));
        chk({tag, ".INT_VEC"}, 32'(b_vec), 32'(10'h000));
        chk({tag, ".INT_ACK"}, 32'(b_ack), 32'(4'h0));
    endtask

    initial begin
        logic [2:0] ea;
        logic [2:0] eb;
        reset   = 1'b1;
        irq     = 4'h0;
        mask    = 4'hF;
        iflag   = 1'b0;
        b_reset = 1'b1;
        b_irq   = 4'h0;
        b_mask  = 4'hF;
        b_iflag = 1'b0;

        // two reset cycles
        tick();
        chk_a("rst1", S_INIT, 10'h0, 4'h0);
        chk_b("rst1b", S_INIT);
        tick();
        chk_a("rst2", S_INIT, 10'h0, 4'h0);
        reset   = 1'b0;
        b_reset = 1'b0;

        // plain sequencing, t=3..10
        for (int k = 0; k < 8; k++) begin
            tick();
            ea = (k % 2 == 0) ? S_FETCH : S_EXEC;
            case (k % 4)
                0:       eb = S_FETCH;
                1:       eb = S_WAIT;
                2:       eb = S_WAIT;
                default: eb = S_EXEC;
            endcase
            chk_a("seqA", ea, 10'h0, 4'h0);
            chk_b("seqB", eb);
        end

        // two sources pending at once: lowest index first
        iflag = 1'b1;
        irq   = 4'b0110;
        tick(); chk_a("p2.f", S_FETCH, 10'h0, 4'h0);
        tick(); chk_a("p2.e", S_EXEC, 10'h0, 4'h0);
        tick(); chk_a("p2.int1", S_INT, 10'h3F9, 4'b0010);
        tick(); chk_a("p2.f2", S_FETCH, 10'h0, 4'h0);
        tick(); chk_a("p2.e2", S_EXEC, 10'h0, 4'h0);
        tick(); chk_a("p2.int2", S_INT, 10'h3FA, 4'b0100);
        tick(); chk_a("p2.f3", S_FETCH, 10'h0, 4'h0);
        irq = 4'h0;
        tick(); chk_a("p2.e3", S_EXEC, 10'h0, 4'h0);
        tick(); chk_a("p2.none", S_FETCH, 10'h0, 4'h0);

        // masked source stays pending until unmasked
        mask = 4'b0111;
        irq  = 4'b1000;
        tick(); chk_a("msk.e", S_EXEC, 10'h0, 4'h0);
        irq = 4'h0;
        tick(); chk_a("msk.f", S_FETCH, 10'h0, 4'h0);
        tick(); chk_a("msk.e2", S_EXEC, 10'h0, 4'h0);
        tick(); chk_a("msk.f2", S_FETCH, 10'h0, 4'h0);
        mask = 4'hF;
        tick(); chk_a("msk.e3", S_EXEC, 10'h0, 4'h0);
        tick(); chk_a("msk.int", S_INT, 10'h3FB, 4'b1000);
        tick(); chk_a("msk.f3", S_FETCH, 10'h0, 4'h0);

        // new edge on the acknowledge cycle keeps the request
        irq = 4'b0001;
        tick(); chk_a("sw.e", S_EXEC, 10'h0, 4'h0);
        irq = 4'b0000;
        tick(); chk_a("sw.int1", S_INT, 10'h3F8, 4'b0001);
        irq = 4'b0001;
        tick(); chk_a("sw.f", S_FETCH, 10'h0, 4'h0);
        tick(); chk_a("sw.e2", S_EXEC, 10'h0, 4'h0);
        tick(); chk_a("sw.int2", S_INT, 10'h3F8, 4'b0001);
        tick(); chk_a("sw.f2", S_FETCH, 10'h0, 4'h0);
        tick(); chk_a("sw.e3", S_EXEC, 10'h0, 4'h0);
        tick(); chk_a("sw.none", S_FETCH, 10'h0, 4'h0);

        // reset mid-WAIT with a pending request and line held high
        chk_b("rw.pre", S_EXEC);
        b_irq = 4'b0001;
        tick(); chk_b("rw.f", S_FETCH);
        tick(); chk_b("rw.w", S_WAIT);
        b_reset = 1'b1;
        tick(); chk_b("rw.init", S_INIT);
        b_reset = 1'b0;
        b_iflag = 1'b1;
        tick(); chk_b("rw.f2", S_FETCH);
        tick(); chk_b("rw.w1", S_WAIT);
        tick(); chk_b("rw.w2", S_WAIT);
        tick(); chk_b("rw.e", S_EXEC);
        tick(); chk_b("rw.noint", S_FETCH);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
